// File: rtl/pocket_scorer.sv
// pocket_scorer
// Turns per-ball pocket indications into game state on the frame clock (vsync).
// Latches sunk balls once only, serializes simultaneous sinkings into one event
// per frame (lowest index first), credits the current player, and decides at
// the end of each shot whether the turn passes.
//
// Optional cue-ball foul handling is compiled in when POCKET_SCORER_FOUL_EN is
// defined; without it cue_in is ignored and no foul is ever recorded.
// NUM_BALLS must be at least 2 so that sink_id has a non-zero width.
module pocket_scorer #(
  parameter int unsigned NUM_BALLS       = 5,
  parameter int unsigned SCORE_W         = 4,
  parameter int unsigned POINTS_PER_BALL = 1
) (
  input  logic                         vsync,
  input  logic                         reset,
  input  logic [NUM_BALLS-1:0]         ball_in,
  input  logic                         shot_active,
  input  logic                         cue_in,
  output logic [NUM_BALLS-1:0]         sunk_mask,
  output logic                         sink_event,
  output logic [$clog2(NUM_BALLS)-1:0] sink_id,
  output logic                         player,
  output logic [SCORE_W-1:0]           score0,
  output logic [SCORE_W-1:0]           score1,
  output logic                         turn_over,
  output logic                         game_over
);

  localparam int unsigned        IdW      = $clog2(NUM_BALLS);
  localparam logic [SCORE_W-1:0] ScoreMax = {SCORE_W{1'b1}};

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StShot     = 2'd1;
  localparam logic [1:0] StResolve  = 2'd2;
  localparam logic [1:0] StGameover = 2'd3;

  // Saturating credit of one ball's worth of points.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s);
    logic [31:0] sum;
    sum = 32'(s) + 32'(POINTS_PER_BALL);
    if (sum > 32'(ScoreMax)) begin
      return ScoreMax;
    end
    return SCORE_W'(sum);
  endfunction

  // Foul penalty, never below zero.
  function automatic logic [SCORE_W-1:0] dec_floor(input logic [SCORE_W-1:0] s);
    return (s == '0) ? s : (s - SCORE_W'(1));
  endfunction

  logic [1:0]           state_q, state_d;
  logic [NUM_BALLS-1:0] sunk_q, sunk_d;
  logic [NUM_BALLS-1:0] pending_q, pending_d;
  logic                 scored_q, scored_d;
  logic                 foul_q, foul_d;
  logic                 player_q, player_d;
  logic [SCORE_W-1:0]   score0_q, score0_d;
  logic [SCORE_W-1:0]   score1_q, score1_d;
  logic                 sink_event_q, sink_event_d;
  logic [IdW-1:0]       sink_id_q, sink_id_d;
  logic                 turn_over_q, turn_over_d;
  logic                 game_over_q, game_over_d;

  logic                 capture_en;
  logic [NUM_BALLS-1:0] new_balls;
  logic                 emit_valid;
  logic [IdW-1:0]       emit_id;
  logic [NUM_BALLS-1:0] emit_onehot;
  logic                 foul_hit;
  logic                 foul_first;
  logic [SCORE_W-1:0]   score_cur;
  logic [SCORE_W-1:0]   score_new;

  // Capture only balls not already sunk, and only while aiming or shooting.
  always_comb begin
    capture_en = (state_q == StIdle) || (state_q == StShot);
    new_balls  = capture_en ? (ball_in & ~sunk_q) : '0;
  end

  // Pick the lowest pending ball. Works on the registered pending set, so a
  // ball captured this cycle cannot emit until the next one.
  always_comb begin
    emit_valid  = |pending_q;
    emit_onehot = pending_q & (~pending_q + NUM_BALLS'(1));
    emit_id     = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        emit_id = IdW'(i);
      end
    end
  end

`ifdef POCKET_SCORER_FOUL_EN
  // A scratch during a shot fouls; only the first one in a shot costs a point.
  always_comb begin
    foul_hit   = (state_q == StShot) && cue_in;
    foul_first = foul_hit && !foul_q;
  end
`else
  // Fouls compiled out: cue_in is intentionally unused.
  logic unused_cue;
  assign unused_cue = cue_in;

  // No foul source in this build.
  always_comb begin
    foul_hit   = 1'b0;
    foul_first = 1'b0;
  end
`endif

  // Apply emit credit then foul debit to whichever player holds the turn.
  always_comb begin
    score_cur = player_q ? score1_q : score0_q;
    score_new = score_cur;
    if (emit_valid) begin
      score_new = sat_add(score_new);
    end
    if (foul_first) begin
      score_new = dec_floor(score_new);
    end
    score0_d = score0_q;
    score1_d = score1_q;
    if (player_q) begin
      score1_d = score_new;
    end else begin
      score0_d = score_new;
    end
  end

  // Shot sequencing, bookkeeping of sunk/pending sets, and turn decision.
  always_comb begin
    state_d      = state_q;
    sunk_d       = sunk_q | new_balls;
    pending_d    = (pending_q & ~emit_onehot) | new_balls;
    scored_d     = scored_q | (emit_valid && (state_q == StShot));
    foul_d       = foul_q | foul_hit;
    player_d     = player_q;
    turn_over_d  = 1'b0;
    game_over_d  = game_over_q;
    sink_event_d = emit_valid;
    sink_id_d    = emit_valid ? emit_id : sink_id_q;

    case (state_q)
      StIdle: begin
        if (shot_active) begin
          state_d  = StShot;
          scored_d = 1'b0;
          foul_d   = 1'b0;
        end
      end
      StShot: begin
        // Hold off the turn decision until every sinking has been credited.
        if (!shot_active && (pending_q == '0)) begin
          state_d = StResolve;
        end
      end
      StResolve: begin
        if (!scored_q || foul_q) begin
          player_d    = ~player_q;
          turn_over_d = 1'b1;
        end
        if (&sunk_q) begin
          state_d     = StGameover;
          game_over_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StGameover: begin
        state_d = StGameover;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge vsync) begin
    if (reset) begin
      state_q      <= StIdle;
      sunk_q       <= '0;
      pending_q    <= '0;
      scored_q     <= 1'b0;
      foul_q       <= 1'b0;
      player_q     <= 1'b0;
      score0_q     <= '0;
      score1_q     <= '0;
      sink_event_q <= 1'b0;
      sink_id_q    <= '0;
      turn_over_q  <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sunk_q       <= sunk_d;
      pending_q    <= pending_d;
      scored_q     <= scored_d;
      foul_q       <= foul_d;
      player_q     <= player_d;
      score0_q     <= score0_d;
      score1_q     <= score1_d;
      sink_event_q <= sink_event_d;
      sink_id_q    <= sink_id_d;
      turn_over_q  <= turn_over_d;
      game_over_q  <= game_over_d;
    end
  end

  assign sunk_mask  = sunk_q;
  assign sink_event = sink_event_q;
  assign sink_id    = sink_id_q;
  assign player     = player_q;
  assign score0     = score0_q;
  assign score1     = score1_q;
  assign turn_over  = turn_over_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_pocket_scorer.sv
// Testbench for pocket_scorer: directed scenarios with spec-derived constants,
// plus randomized play checked every frame against a behavioural game model.
module tb_pocket_scorer;

  localparam int NB  = 5;
  localparam int SW  = 2;
  localparam int IW  = 3;
  localparam int PTS = 1;
  localparam int SMAX = (1 << SW) - 1;
`ifdef POCKET_SCORER_FOUL_EN
  localparam bit FoulEn = 1'b1;
`else
  localparam bit FoulEn = 1'b0;
`endif

  logic          vsync;
  logic          reset;
  logic [NB-1:0] ball_in;
  logic          shot_active;
  logic          cue_in;
  logic [NB-1:0] sunk_mask;
  logic          sink_event;
  logic [IW-1:0] sink_id;
  logic          player;
  logic [SW-1:0] score0;
  logic [SW-1:0] score1;
  logic          turn_over;
  logic          game_over;

  int checks;
  int errors;

  pocket_scorer #(
    .NUM_BALLS      (NB),
    .SCORE_W        (SW),
    .POINTS_PER_BALL(PTS)
  ) dut (
    .vsync      (vsync),
    .reset      (reset),
    .ball_in    (ball_in),
    .shot_active(shot_active),
    .cue_in     (cue_in),
    .sunk_mask  (sunk_mask),
    .sink_event (sink_event),
    .sink_id    (sink_id),
    .player     (player),
    .score0     (score0),
    .score1     (score1),
    .turn_over  (turn_over),
    .game_over  (game_over)
  );

  initial vsync = 1'b0;
  always #5 vsync = ~vsync;

  // Behavioural game model: phase 0 aiming, 1 balls moving, 2 resolving, 3 over.
  int m_phase;
  bit m_sunk [NB];
  bit m_pend [NB];
  int m_score [2];
  int m_player;
  bit m_scored;
  bit m_foul;
  bit m_ev;
  int m_id;
  bit m_turn;
  bit m_go;

  task automatic model_reset();
    m_phase  = 0;
    for (int i = 0; i < NB; i++) begin
      m_sunk[i] = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_score[0] = 0;
    m_score[1] = 0;
    m_player = 0;
    m_scored = 1'b0;
    m_foul   = 1'b0;
    m_ev     = 1'b0;
    m_id     = 0;
    m_turn   = 1'b0;
    m_go     = 1'b0;
  endtask

  // One frame of game rules given the inputs seen at that frame's edge.
  task automatic model_step(input logic [NB-1:0] b, input logic s, input logic c);
    int  pick;
    bit  any_pend;
    bit  all_sunk;
    pick = -1;
    for (int i = 0; i < NB; i++) begin
      if (m_pend[i] && pick < 0) pick = i;
    end
    any_pend = (pick >= 0);
    all_sunk = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if (!m_sunk[i]) all_sunk = 1'b0;
    end
    m_ev   = 1'b0;
    m_turn = 1'b0;
    if (any_pend) begin
      m_pend[pick] = 1'b0;
      m_score[m_player] = (m_score[m_player] + PTS > SMAX) ? SMAX : m_score[m_player] + PTS;
      if (m_phase == 1) m_scored = 1'b1;
      m_ev = 1'b1;
      m_id = pick;
    end
    if (FoulEn && m_phase == 1 && c === 1'b1) begin
      if (!m_foul && m_score[m_player] > 0) m_score[m_player] = m_score[m_player] - 1;
      m_foul = 1'b1;
    end
    if (m_phase <= 1) begin
      for (int i = 0; i < NB; i++) begin
        if (b[i] === 1'b1 && !m_sunk[i]) begin
          m_sunk[i] = 1'b1;
          m_pend[i] = 1'b1;
        end
      end
    end
    case (m_phase)
      0: if (s === 1'b1) begin
        m_phase  = 1;
        m_scored = 1'b0;
        m_foul   = 1'b0;
      end
      1: if (s !== 1'b1 && !any_pend) m_phase = 2;
      2: begin
        if (!m_scored || m_foul) begin
          m_player = 1 - m_player;
          m_turn   = 1'b1;
        end
        if (all_sunk) begin
          m_phase = 3;
          m_go    = 1'b1;
        end else begin
          m_phase = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick(input logic [NB-1:0] b, input logic s, input logic c);
    ball_in     = b;
    shot_active = s;
    cue_in      = c;
    @(posedge vsync);
    #1;
    model_step(b, s, c);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    ball_in     = '0;
    shot_active = 1'b0;
    cue_in      = 1'b0;
    @(posedge vsync);
    @(posedge vsync);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({sunk_mask, sink_event, sink_id, player, score0, score1, turn_over, game_over} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0",
               {sunk_mask, sink_event, sink_id, player, score0, score1, turn_over, game_over});
    end
  endtask

  task automatic test_reset_mid_shot();
    do_reset();
    tick('0, 1'b1, 1'b0);
    tick(5'b11111, 1'b1, 1'b0);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick('0, 1'b0, 1'b0);
      checks++;
      if (sink_event !== 1'b0 || score0 !== '0 || sunk_mask !== '0) begin
        errors++;
        $display("FAIL mid_shot_reset got ev=%b s0=%0d mask=%b exp ev=0 s0=0 mask=0",
                 sink_event, score0, sunk_mask);
      end
    end
  endtask

  task automatic test_single_sink();
    do_reset();
    tick('0, 1'b1, 1'b0);
    tick(5'b00100, 1'b1, 1'b0);
    checks++;
    if (sunk_mask !== 5'b00100 || sink_event !== 1'b0) begin
      errors++;
      $display("FAIL single_capture got mask=%b ev=%b exp mask=00100 ev=0", sunk_mask, sink_event);
    end
    tick('0, 1'b1, 1'b0);
    checks++;
    if (sink_event !== 1'b1 || sink_id !== 3'd2 || score0 !== 2'd1) begin
      errors++;
      $display("FAIL single_emit got ev=%b id=%0d s0=%0d exp ev=1 id=2 s0=1",
               sink_event, sink_id, score0);
    end
    tick('0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    checks++;
    if (turn_over !== 1'b0 || player !== 1'b0) begin
      errors++;
      $display("FAIL single_keep_turn got turn=%b player=%b exp turn=0 player=0",
               turn_over, player);
    end
  endtask

  task automatic test_simultaneous();
    logic [IW-1:0] exp_ids [3];
    exp_ids[0] = 3'd0;
    exp_ids[1] = 3'd1;
    exp_ids[2] = 3'd4;
    do_reset();
    tick('0, 1'b1, 1'b0);
    tick(5'b10011, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick('0, 1'b0, 1'b0);
      checks++;
      if (sink_event !== 1'b1 || sink_id !== exp_ids[k] || score0 !== SW'(k + 1)) begin
        errors++;
        $display("FAIL simul_emit%0d got ev=%b id=%0d s0=%0d exp ev=1 id=%0d s0=%0d",
                 k, sink_event, sink_id, score0, exp_ids[k], k + 1);
      end
    end
    tick('0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    checks++;
    if (turn_over !== 1'b0 || player !== 1'b0 || sink_event !== 1'b0) begin
      errors++;
      $display("FAIL simul_resolve got turn=%b player=%b ev=%b exp 0 0 0",
               turn_over, player, sink_event);
    end
  endtask

  task automatic test_duplicate();
    int evs;
    evs = 0;
    do_reset();
    tick('0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick(5'b00010, 1'b1, 1'b0);
      if (sink_event === 1'b1) evs++;
    end
    for (int k = 0; k < 3; k++) begin
      tick('0, 1'b1, 1'b0);
      if (sink_event === 1'b1) evs++;
    end
    checks++;
    if (evs != 1 || score0 !== 2'd1 || sunk_mask !== 5'b00010) begin
      errors++;
      $display("FAIL dup_suppress got events=%0d s0=%0d mask=%b exp events=1 s0=1 mask=00010",
               evs, score0, sunk_mask);
    end
  endtask

  task automatic test_empty_shot();
    do_reset();
    for (int k = 0; k < 20; k++) tick('0, 1'b1, 1'b0);
    tick('0, 1'b0, 1'b0);
    checks++;
    if (turn_over !== 1'b0 || player !== 1'b0) begin
      errors++;
      $display("FAIL empty_early_turn got turn=%b player=%b exp 0 0", turn_over, player);
    end
    tick('0, 1'b0, 1'b0);
    checks++;
    if (turn_over !== 1'b1 || player !== 1'b1) begin
      errors++;
      $display("FAIL empty_turn got turn=%b player=%b exp 1 1", turn_over, player);
    end
    tick('0, 1'b0, 1'b0);
    checks++;
    if (turn_over !== 1'b0) begin
      errors++;
      $display("FAIL empty_turn_pulse got turn=%b exp 0", turn_over);
    end
    tick('0, 1'b1, 1'b0);
    tick(5'b00001, 1'b1, 1'b0);
    tick('0, 1'b1, 1'b0);
    checks++;
    if (sink_event !== 1'b1 || score1 !== 2'd1 || score0 !== 2'd0) begin
      errors++;
      $display("FAIL empty_p1_credit got ev=%b s1=%0d s0=%0d exp ev=1 s1=1 s0=0",
               sink_event, score1, score0);
    end
  endtask

  task automatic test_game_over();
    do_reset();
    tick('0, 1'b1, 1'b0);
    tick(5'b00111, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) tick('0, 1'b1, 1'b0);
    tick('0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    checks++;
    if (score0 !== 2'd3 || player !== 1'b0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL go_first_shot got s0=%0d player=%b go=%b exp 3 0 0",
               score0, player, game_over);
    end
    tick('0, 1'b1, 1'b0);
    tick(5'b11000, 1'b1, 1'b0);
    tick('0, 1'b1, 1'b0);
    tick('0, 1'b1, 1'b0);
    checks++;
    if (score0 !== 2'd3 || sink_id !== 3'd4) begin
      errors++;
      $display("FAIL go_saturate got s0=%0d id=%0d exp s0=3 id=4", score0, sink_id);
    end
    tick('0, 1'b0, 1'b0);
    checks++;
    if (game_over !== 1'b0) begin
      errors++;
      $display("FAIL go_early got go=%b exp 0", game_over);
    end
    tick('0, 1'b0, 1'b0);
    checks++;
    if (game_over !== 1'b1 || sunk_mask !== 5'b11111 || player !== 1'b0 || turn_over !== 1'b0) begin
      errors++;
      $display("FAIL go_final got go=%b mask=%b player=%b turn=%b exp 1 11111 0 0",
               game_over, sunk_mask, player, turn_over);
    end
    for (int k = 0; k < 12; k++) begin
      tick(NB'($urandom()), 1'($urandom()), 1'($urandom()));
      checks++;
      if (score0 !== 2'd3 || score1 !== 2'd0 || player !== 1'b0 || sink_event !== 1'b0 ||
          turn_over !== 1'b0 || game_over !== 1'b1) begin
        errors++;
        $display("FAIL go_absorb%0d got s0=%0d s1=%0d p=%b ev=%b turn=%b go=%b exp 3 0 0 0 0 1",
                 k, score0, score1, player, sink_event, turn_over, game_over);
      end
    end
    do_reset();
    checks++;
    if ({sunk_mask, sink_event, sink_id, player, score0, score1, turn_over, game_over} !== '0) begin
      errors++;
      $display("FAIL go_reset got=%b exp=0",
               {sunk_mask, sink_event, sink_id, player, score0, score1, turn_over, game_over});
    end
  endtask

  task automatic test_foul();
    do_reset();
    tick('0, 1'b1, 1'b0);
    tick(5'b00011, 1'b1, 1'b0);
    tick('0, 1'b1, 1'b0);
    tick('0, 1'b1, 1'b0);
    tick('0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    checks++;
    if (score0 !== 2'd2 || player !== 1'b0) begin
      errors++;
      $display("FAIL foul_setup got s0=%0d player=%b exp 2 0", score0, player);
    end
    tick('0, 1'b1, 1'b0);
    tick(5'b00100, 1'b1, 1'b1);
    checks++;
    if (score0 !== (FoulEn ? 2'd1 : 2'd2)) begin
      errors++;
      $display("FAIL foul_penalty got s0=%0d exp %0d", score0, FoulEn ? 1 : 2);
    end
    tick('0, 1'b1, 1'b1);
    tick('0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    checks++;
    if (score0 !== (FoulEn ? 2'd2 : 2'd3) || turn_over !== FoulEn || player !== FoulEn) begin
      errors++;
      $display("FAIL foul_resolve got s0=%0d turn=%b player=%b exp s0=%0d turn=%b player=%b",
               score0, turn_over, player, FoulEn ? 2 : 3, FoulEn, FoulEn);
    end
  endtask

  task automatic test_random();
    logic          shot;
    logic [NB-1:0] b;
    logic          c;
    logic [NB-1:0] exp_mask;
    for (int g = 0; g < 6; g++) begin
      do_reset();
      shot = 1'b0;
      for (int cyc = 0; cyc < 250; cyc++) begin
        if ($urandom_range(0, 9) == 0) shot = ~shot;
        b = ($urandom_range(0, 5) == 0) ? NB'($urandom()) : '0;
        c = ($urandom_range(0, 15) == 0);
        tick(b, shot, c);
        for (int i = 0; i < NB; i++) exp_mask[i] = m_sunk[i];
        checks++;
        if (sunk_mask !== exp_mask) begin
          errors++;
          $display("FAIL rnd_mask g=%0d cyc=%0d got=%b exp=%b", g, cyc, sunk_mask, exp_mask);
        end
        checks++;
        if (sink_event !== m_ev) begin
          errors++;
          $display("FAIL rnd_event g=%0d cyc=%0d got=%b exp=%b", g, cyc, sink_event, m_ev);
        end
        if (m_ev) begin
          checks++;
          if (sink_id !== IW'(m_id)) begin
            errors++;
            $display("FAIL rnd_id g=%0d cyc=%0d got=%0d exp=%0d", g, cyc, sink_id, m_id);
          end
        end
        checks++;
        if (score0 !== SW'(m_score[0]) || score1 !== SW'(m_score[1])) begin
          errors++;
          $display("FAIL rnd_score g=%0d cyc=%0d got=%0d/%0d exp=%0d/%0d",
                   g, cyc, score0, score1, m_score[0], m_score[1]);
        end
        checks++;
        if (player !== 1'(m_player) || turn_over !== m_turn || game_over !== m_go) begin
          errors++;
          $display("FAIL rnd_turn g=%0d cyc=%0d got p=%b t=%b go=%b exp p=%0d t=%b go=%b",
                   g, cyc, player, turn_over, game_over, m_player, m_turn, m_go);
        end
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    ball_in     = '0;
    shot_active = 1'b0;
    cue_in      = 1'b0;
    model_reset();
    test_reset();
    test_reset_mid_shot();
    test_single_sink();
    test_simultaneous();
    test_duplicate();
    test_empty_shot();
    test_game_over();
    test_foul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pocket_scorer.md
# pocket_scorer

Consumes the per-ball "ball in pocket" pulses produced by the pocket detection stage and turns them into game state. It latches which balls are sunk, serializes simultaneous sinkings into one event per frame, and credits points to the current player. At the end of each shot it decides whether the turn passes. It runs on the frame clock (vsync), downstream of pocket detection and upstream of the score/HUD renderer and the ball physics disable logic.

## Interface
Parameters:
- NUM_BALLS, 5, number of object balls; ball_in and sunk_mask width.
- SCORE_W, 4, width of each player's score register.
- POINTS_PER_BALL, 1, points credited per sunk ball.

Ports:
- vsync  in  1  frame clock; all logic on posedge.
- reset  in  1  reset, synchronous, active-high.
- ball_in  in  NUM_BALLS  per-ball pocket indications from detection; may be pulses or levels, may assert together.
- shot_active  in  1  high while any ball is moving.
- cue_in  in  1  cue ball pocketed (scratch) indication.
- sunk_mask  out  NUM_BALLS  bit i = ball i sunk; drives ball hiding and physics disable.
- sink_event  out  1  one-cycle pulse per sunk ball.
- sink_id  out  $clog2(NUM_BALLS)  ball index qualified by sink_event.
- player  out  1  current player, 0 or 1.
- score0, score1  out  SCORE_W  player scores.
- turn_over  out  1  one-cycle pulse when the turn passes.
- game_over  out  1  all balls sunk; sticky.

## Operation
- State machine: IDLE (aiming), SHOT (balls moving), RESOLVE (one cycle), GAMEOVER.
- IDLE -> SHOT when shot_active = 1. On entry, clear scored_this_shot and foul.
- SHOT -> RESOLVE when shot_active = 0 and pending = 0.
- RESOLVE -> GAMEOVER if sunk_mask is all ones, else -> IDLE.
- GAMEOVER is absorbing until reset. In GAMEOVER, ball_in and cue_in are ignored.
- Capture, in IDLE and SHOT: new = ball_in & ~sunk_mask. OR new into both sunk_mask and pending.
  - A ball is captured once only. Re-pulses or held levels of a sunk ball are ignored.
- Emitter: each cycle with pending != 0, pick the lowest set index.
  - Pulse sink_event with that sink_id.
  - Clear its pending bit.
  - Add POINTS_PER_BALL to the current player's score, saturating at 2^SCORE_W-1.
  - Set scored_this_shot if in SHOT.
- Capture and emit happen in the same cycle without conflict. A newly captured bit never emits in its capture cycle.
- RESOLVE: if scored_this_shot = 0 or foul = 1, toggle player and pulse turn_over. Otherwise the same player keeps the turn.
- Balls sunk in IDLE are credited to the current player but do not affect turn logic.
- Reset values:
  - sunk_mask = 0, pending = 0
  - sink_event = 0, sink_id = 0
  - player = 0, score0 = score1 = 0
  - turn_over = 0, game_over = 0
  - state = IDLE
- Reset mid-shot discards pending events; no score is credited.

## Timing
- All outputs are registered.
- ball_in sampled at edge k: sunk_mask bit visible after edge k.
- First sink_event, with its score update, is visible after edge k+1.
- m simultaneous new balls produce m events on consecutive cycles, after edges k+1 .. k+m, lowest index first.
- shot_active falls at edge j with pending empty: RESOLVE after edge j.
  - turn_over and player toggle visible after edge j+1.
  - game_over is visible after edge j+1 if all balls are sunk.
- If pending is non-empty when shot_active falls, RESOLVE waits until the edge after the last emit.
- shot_active re-rising during RESOLVE is honored on the following IDLE cycle.

## Configuration
- POCKET_SCORER_FOUL_EN defined:
  - cue_in = 1 in SHOT sets foul.
  - On the first cue_in of a shot, the current player's score decrements by 1, floored at 0.
  - foul forces a turn change at RESOLVE even if balls were scored.
- POCKET_SCORER_FOUL_EN undefined: cue_in is ignored and foul is held at 0.

## Test plan
- Single sink: after reset, shot_active = 1, then ball_in = 5'b00100 for 1 cycle.
  - Required: sunk_mask = 00100 next cycle.
  - Required: sink_event with sink_id = 2 the cycle after, score0 = 1.
  - Drop shot_active: no turn_over, player stays 0.
- Simultaneous: ball_in = 5'b10011 in one cycle.
  - Required: sink_id sequence 0, 1, 4 on three consecutive cycles; score0 = 3.
  - RESOLVE is delayed until pending empties even if shot_active already fell.
- Duplicate suppression: hold ball_in[1] = 1 for 10 cycles.
  - Required: exactly one sink_event and score += 1.
- Empty shot: shot_active high 20 cycles, no ball_in.
  - Required: turn_over pulse one cycle after RESOLVE; player = 1.
  - Next scored ball credits score1.
- Game over and saturation: SCORE_W = 2, sink all 5 balls across shots by player 0.
  - Required: score0 saturates at 3; game_over = 1 after the final RESOLVE.
  - Further ball_in / shot_active cause no change until reset, after which all outputs are 0.
- Foul (FOUL_EN defined): score0 = 2, one ball sunk and cue_in in the same shot.
  - Required: score0 = 2 (+1 −1) and turn_over at RESOLVE.
  - Without the macro: score0 = 3 and no turn_over.
